// File: rtl/wb_trace_pkg.sv
// Shared types for the write-back trace buffer: one 84-bit trace entry and the default FIFO depth.
package wb_trace_pkg;

    localparam int TRACE_DEPTH_DEF = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  rn;
        logic [31:0] data;
        logic [15:0] seq;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular buffer accepting up to two entries and releasing one entry per cycle.
// The caller guarantees i_push_n never exceeds the free space.
module trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic [1:0]   i_push_n,
    input  trace_entry_t i_e0,
    input  trace_entry_t i_e1,
    input  logic         i_pop,
    output trace_entry_t o_head,
    output logic [AW:0]  o_level
);

    trace_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [AW:0]     r_level;
    logic [AW-1:0]   w_wp1;

    assign w_wp1 = r_wp + AW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else if (i_clear) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            r_wp    <= r_wp + AW'(i_push_n);
            r_rp    <= r_rp + AW'(i_pop);
            r_level <= r_level + (AW+1)'(i_push_n) - (AW+1)'(i_pop);
        end
    end

    // Storage carries no reset; the top masks the head while empty.
    always_ff @(posedge clk) begin
        if (!i_clear && i_push_n != 2'd0) r_mem[r_wp]  <= i_e0;
        if (!i_clear && i_push_n == 2'd2) r_mem[w_wp1] <= i_e1;
    end

    assign o_head  = r_mem[r_rp];
    assign o_level = r_level;

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace capture: decodes retire events, stamps sequence numbers, drops whole events on overflow.
// Define WB_TRACE_DUAL_WRITE_EN to also trace the second (long multiply) write as its own entry.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               RegWriteW,
    input  logic [3:0]               WA3W,
    input  logic [3:0]               WA3W2,
    input  logic [63:0]              ResultW,
    input  logic [31:0]              PCPlus8W,
    input  logic                     clear,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_pc,
    output logic [3:0]               trace_reg,
    output logic [31:0]              trace_data,
    output logic [15:0]              trace_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0]   r_seq;
    logic          r_ovf;
    logic [31:0]   w_pc;
    logic [1:0]    w_need;
    logic [1:0]    w_push_n;
    logic [AW:0]   w_free;
    logic          w_fits;
    logic          w_pop;
    trace_entry_t  w_e0;
    trace_entry_t  w_e1;
    trace_entry_t  w_head;

    assign w_pc = PCPlus8W - 32'd8;

`ifdef WB_TRACE_DUAL_WRITE_EN
    assign w_need = {1'b0, RegWriteW[0]} + {1'b0, RegWriteW[1]};

    // A lone second write still lands in slot 0 so the FIFO sees packed pushes.
    always_comb begin
        w_e0 = '{pc: w_pc, rn: WA3W, data: ResultW[31:0], seq: r_seq};
        w_e1 = '{pc: w_pc, rn: WA3W2, data: ResultW[63:32], seq: r_seq + 16'd1};
        if (!RegWriteW[0]) begin
            w_e0 = '{pc: w_pc, rn: WA3W2, data: ResultW[63:32], seq: r_seq};
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{RegWriteW[1], WA3W2, ResultW[63:32]};
    assign w_need   = {1'b0, RegWriteW[0]};

    always_comb begin
        w_e0 = '{pc: w_pc, rn: WA3W, data: ResultW[31:0], seq: r_seq};
        w_e1 = w_e0;
    end
`endif

    assign trace_valid = (level != '0);
    assign w_pop       = trace_valid && trace_ready;
    assign w_free      = (AW+1)'(DEPTH) - level + (AW+1)'(w_pop);
    assign w_fits      = (AW+1)'(w_need) <= w_free;
    assign w_push_n    = (clear || !w_fits) ? 2'd0 : w_need;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seq <= '0;
            r_ovf <= 1'b0;
        end else if (clear) begin
            r_seq <= '0;
            r_ovf <= 1'b0;
        end else if (w_need != 2'd0) begin
            r_seq <= r_seq + 16'(w_need);
            if (!w_fits) r_ovf <= 1'b1;
        end
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (clear),
        .i_push_n (w_push_n),
        .i_e0     (w_e0),
        .i_e1     (w_e1),
        .i_pop    (w_pop && !clear),
        .o_head   (w_head),
        .o_level  (level)
    );

    assign trace_pc   = trace_valid ? w_head.pc   : '0;
    assign trace_reg  = trace_valid ? w_head.rn   : '0;
    assign trace_data = trace_valid ? w_head.data : '0;
    assign trace_seq  = trace_valid ? w_head.seq  : '0;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: an event-level queue model feeds expected entries to a negedge monitor.
module tb_wb_trace_buffer;
    import wb_trace_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  RegWriteW = '0;
    logic [3:0]  WA3W = '0, WA3W2 = '0;
    logic [63:0] ResultW = '0;
    logic [31:0] PCPlus8W = '0;
    logic        clear = 1'b0;
    logic        trace_ready = 1'b0;
    logic        trace_valid;
    logic [31:0] trace_pc, trace_data;
    logic [3:0]  trace_reg;
    logic [15:0] trace_seq;
    logic [$clog2(DEPTH):0] level;
    logic        overflow;

    wb_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .WA3W(WA3W), .WA3W2(WA3W2),
        .ResultW(ResultW), .PCPlus8W(PCPlus8W), .clear(clear), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_pc(trace_pc), .trace_reg(trace_reg),
        .trace_data(trace_data), .trace_seq(trace_seq), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    trace_entry_t sb[$];
    logic [15:0]  mseq = '0;
    logic         movf = 1'b0;
    int           n_chk = 0;
    int           n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: state after the last edge; a head with ready high leaves at the next edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("valid", 64'(trace_valid), 64'(sb.size() != 0));
            chk("level", 64'(level), 64'(sb.size()));
            chk("overflow", 64'(overflow), 64'(movf));
            if (sb.size() != 0) begin
                chk("pc",   64'(trace_pc),   64'(sb[0].pc));
                chk("reg",  64'(trace_reg),  64'(sb[0].rn));
                chk("data", 64'(trace_data), 64'(sb[0].data));
                chk("seq",  64'(trace_seq),  64'(sb[0].seq));
                if (trace_ready) void'(sb.pop_front());
            end
        end
    end

    // Reference: apply the inputs that were just clocked to the model queue.
    task automatic commit();
        trace_entry_t ents[$];
        if (!reset) return;
        if (clear) begin
            sb.delete();
            mseq = '0;
            movf = 1'b0;
            return;
        end
        if (RegWriteW[0]) ents.push_back('{pc: PCPlus8W - 32'd8, rn: WA3W, data: ResultW[31:0], seq: 16'd0});
`ifdef WB_TRACE_DUAL_WRITE_EN
        if (RegWriteW[1]) ents.push_back('{pc: PCPlus8W - 32'd8, rn: WA3W2, data: ResultW[63:32], seq: 16'd0});
`endif
        if (ents.size() > DEPTH - sb.size()) begin
            movf = 1'b1;
            mseq = mseq + 16'(ents.size());
        end else begin
            foreach (ents[i]) begin
                ents[i].seq = mseq;
                mseq = mseq + 16'd1;
                sb.push_back(ents[i]);
            end
        end
    endtask

    task automatic step(input logic [1:0] rw, input logic [3:0] a, input logic [3:0] a2,
                        input logic [63:0] res, input logic [31:0] pc, input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        commit();
        RegWriteW = rw; WA3W = a; WA3W2 = a2; ResultW = res; PCPlus8W = pc;
        trace_ready = rdy; clear = clr;
    endtask

    task automatic ev(input logic rdy);
        step(2'b01, 4'($urandom), 4'($urandom), {$urandom, $urandom}, $urandom, rdy, 1'b0);
    endtask

    task automatic idle(input logic rdy, input logic clr);
        step(2'b00, '0, '0, '0, '0, rdy, clr);
    endtask

    initial begin
        #1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid", 64'(trace_valid), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_data", 64'(trace_data), 64'd0);
        // First edge after release captures this event: pc 0x08, reg 3, data 10, seq 0.
        RegWriteW = 2'b01; WA3W = 4'd3; ResultW = 64'h0000_0000_0000_000A; PCPlus8W = 32'h10;
        #12 reset = 1'b1;
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
`ifdef WB_TRACE_DUAL_WRITE_EN
        idle(1'b0, 1'b1);
        step(2'b11, 4'd1, 4'd2, 64'h0000_0005_FFFF_FFFE, 32'h100, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
`endif
        // Overflow: nine singles into an undrained FIFO, then drain with one more event.
        idle(1'b0, 1'b1);
        repeat (9) ev(1'b0);
        idle(1'b0, 1'b0);
        ev(1'b1);
        repeat (10) idle(1'b1, 1'b0);
        // Full FIFO with a same-cycle pop and push.
        idle(1'b0, 1'b1);
        repeat (8) ev(1'b0);
        ev(1'b1);
        idle(1'b0, 1'b0);
        // Clear at level 5 beats a simultaneous push.
        repeat (5) ev(1'b0);
        step(2'b01, 4'd7, 4'd0, 64'h55, 32'h40, 1'b0, 1'b1);
        idle(1'b0, 1'b0);
        ev(1'b1);
        idle(1'b1, 1'b0);
        // Reset at level 4 discards everything at once.
        repeat (4) ev(1'b0);
        idle(1'b0, 1'b0);
        @(posedge clk);
        #1;
        commit();
        RegWriteW = '0; trace_ready = 1'b0; clear = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_valid", 64'(trace_valid), 64'd0);
        chk("mid_rst_seq", 64'(trace_seq), 64'd0);
        chk("mid_rst_pc", 64'(trace_pc), 64'd0);
        sb.delete(); mseq = '0; movf = 1'b0;
        #1 reset = 1'b1;
        ev(1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(2'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom}, $urandom,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 59) == 0));
        end
        repeat (DEPTH + 3) idle(1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("drain_level", 64'(level), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count (power of two, >=4).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port RegWriteW  input  2  write-back enables; bit0 primary write, bit1 second write (long multiply).
REQ-005 SHALL have port WA3W  input  4  primary destination register.
REQ-006 SHALL have port WA3W2  input  4  second destination register.
REQ-007 SHALL have port ResultW  input  64  write-back result; [31:0] primary data, [63:32] second data.
REQ-008 SHALL have port PCPlus8W  input  32  PC+8 of the retiring instruction.
REQ-009 SHALL have port clear  input  1  synchronous flush.
REQ-010 SHALL have port trace_valid  output  1  head entry available.
REQ-011 SHALL have port trace_ready  input  1  consumer accepts head.
REQ-012 SHALL have ports trace_pc/trace_reg/trace_data/trace_seq  output  32/4/32/16  head entry fields.
REQ-013 SHALL have port level  output  clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port overflow  output  1  sticky drop flag.

Function
REQ-015 SHALL capture one write-back event per rising clk edge when RegWriteW != 0.
REQ-016 Primary entry SHALL be {pc=PCPlus8W-8, reg=WA3W, data=ResultW[31:0]}.
REQ-017 Second entry (RegWriteW[1]) SHALL be {pc=PCPlus8W-8, reg=WA3W2, data=ResultW[63:32]}, ordered after the primary.
REQ-018 trace_valid SHALL equal (level != 0); head fields SHALL be first-word-fall-through, visible the cycle after the push edge.
REQ-019 Pop SHALL occur on edge where trace_valid && trace_ready; trace_ready while empty SHALL be ignored.
REQ-020 Free slots SHALL be computed as DEPTH-level+pop, so a same-cycle pop frees space for a push.
REQ-021 An event needing more slots than free SHALL be dropped entirely (no partial push) and SHALL set overflow.
REQ-022 Each entry (pushed or dropped) SHALL receive the next trace_seq value; seq SHALL wrap 0xFFFF->0x0000, making drops visible as gaps.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; level SHALL saturate neither above DEPTH nor below 0.
REQ-024 clear SHALL empty the FIFO, zero seq and overflow, and take priority over same-cycle push and pop.
REQ-025 overflow SHALL remain set until clear or reset.

Reset
REQ-026 On reset low, level=0, trace_valid=0, overflow=0, seq=0, pointers=0, immediately and asynchronously.
REQ-027 Head data outputs SHALL read 0 while empty after reset; reset mid-operation SHALL discard all entries.
REQ-028 The first edge after reset release SHALL capture events normally.

Configuration
REQ-029 Macro WB_TRACE_DUAL_WRITE_EN defined: REQ-017 active, dual event pushes two entries in one cycle.
REQ-030 Macro undefined: RegWriteW[1] and WA3W2/ResultW[63:32] SHALL be ignored; at most one push per cycle.

Structure
REQ-031 Package wb_trace_pkg SHALL hold the entry typedef (pc, reg, data, seq; 84 bits) and DEPTH default constant.
REQ-032 Sub-module trace_fifo SHALL implement the dual-push, single-pop circular buffer; wb_trace_buffer SHALL hold event decode, seq and overflow logic.

Verification
REQ-033 RegWriteW=01, WA3W=3, ResultW=0x...0000000A, PCPlus8W=0x10 -> next cycle trace_valid=1, pc=0x08, reg=3, data=10, seq=0.
REQ-034 (DUAL_WRITE_EN) RegWriteW=11, WA3W=1, WA3W2=2, ResultW=0x00000005_FFFFFFFE -> two entries reg1/0xFFFFFFFE seq0, reg2/5 seq1, level=2.
REQ-035 trace_ready=0, push 8 single events then a 9th -> level=8, overflow=1, ninth dropped, later entry shows seq=9.
REQ-036 Full FIFO, trace_ready=1 plus single push same cycle -> event accepted, level stays 8, overflow=0.
REQ-037 Level=5, clear=1 with push same cycle -> level=0, trace_valid=0, seq=0, overflow=0.
REQ-038 Level=4, reset asserted mid-cycle -> outputs zero immediately; first post-reset event gets seq=0.
